conv_layer_seq: RTL and testbench

CONV_LAYER_SEQ -- requirements
Module: conv_layer_seq

---
 rtl/conv_layer_seq_pkg.sv | 38 +++
 rtl/conv_layer_seq_mac.sv | 58 +++++
 rtl/conv_layer_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_conv_layer_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_layer_seq_pkg.sv
// Shared definitions for the sequential convolution layer: FSM states,
// output-geometry helper and the result saturate/ReLU function.
package conv_layer_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  function automatic int out_size(input int in_size, input int filt_size, input int stride);
    return (in_size - filt_size) / stride + 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] sat_relu(input logic signed [63:0] value, input logic relu_en);
    logic [31:0] res;
    if (value > 64'sh0000_0000_7FFF_FFFF) begin
      res = 32'h7FFF_FFFF;
    end else if (value < 64'shFFFF_FFFF_8000_0000) begin
      res = 32'h8000_0000;
    end else begin
      res = value[31:0];
    end
    if (relu_en && res[31]) begin
      res = 32'h0000_0000;
    end else begin
      res = res;
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_layer_seq_mac.sv
// Multiply-accumulate datapath: bias preset, per-tap accumulate, and the
// final arithmetic shift with saturation/ReLU into a held result register.
module conv_mac
  import conv_layer_seq_pkg::*;
#(
  parameter int FRAC_BITS = 16,
  parameter int RELU_EN   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_preset,
  input  logic [31:0] i_bias,
  input  logic        i_acc_en,
  input  logic [31:0] i_data,
  input  logic [31:0] i_weight,
  input  logic        i_load_out,
  output logic [31:0] o_result
);

  logic signed [63:0] r_acc;
  logic        [31:0] r_result;
  logic signed [63:0] w_prod;
  logic signed [63:0] w_preset;
  logic signed [63:0] w_acc_sum;
  logic signed [63:0] w_acc_fin;
  logic signed [63:0] w_shifted;

  assign w_prod    = $signed(i_data) * $signed(i_weight);
  assign w_preset  = $signed({{32{i_bias[31]}}, i_bias}) <<< FRAC_BITS;
  assign w_acc_sum = r_acc + w_prod;
  // The result is captured in the same cycle the last product lands.
  assign w_acc_fin = i_acc_en ? w_acc_sum : r_acc;
  assign w_shifted = w_acc_fin >>> FRAC_BITS;

  // Accumulator and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= 64'sd0;
      r_result <= 32'd0;
    end else begin
      if (i_preset) begin
        r_acc <= w_preset;
      end else if (i_acc_en) begin
        r_acc <= w_acc_sum;
      end else begin
        r_acc <= r_acc;
      end
      if (i_load_out) begin
        r_result <= sat_relu(w_shifted, RELU_EN != 0);
      end else begin
        r_result <= r_result;
      end
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/conv_layer_seq.sv
// Sequential convolution layer: walks filters/rows/columns, streams taps from
// input and weight memories into conv_mac, and hands each result to the sink.
module conv_layer_seq
  import conv_layer_seq_pkg::*;
#(
  parameter int NUM_FILTERS  = 16,
  parameter int NUM_CHANNELS = 1,
  parameter int INPUT_SIZE   = 28,
  parameter int FILTER_SIZE  = 7,
  parameter int STRIDE       = 2,
  parameter int FRAC_BITS    = 16,
  parameter int RELU_EN      = 0,
  localparam int OUT_SIZE    = out_size(INPUT_SIZE, FILTER_SIZE, STRIDE),
  localparam int IN_AW       = cnt_width(NUM_CHANNELS * INPUT_SIZE * INPUT_SIZE),
  localparam int W_AW        = cnt_width(NUM_FILTERS * NUM_CHANNELS * FILTER_SIZE * FILTER_SIZE),
  localparam int OUT_AW      = cnt_width(NUM_FILTERS * OUT_SIZE * OUT_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [IN_AW-1:0]          in_addr,
  input  logic [31:0]               input_data,
  output logic [W_AW-1:0]           w_addr,
  input  logic [31:0]               filter_weights,
  input  logic [NUM_FILTERS*32-1:0] bias,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_AW-1:0]         out_addr,
  output logic [31:0]               output_data
);

  localparam int FW        = cnt_width(NUM_FILTERS);
  localparam int OW        = cnt_width(OUT_SIZE);
  localparam int CHW       = cnt_width(NUM_CHANNELS);
  localparam int KW        = cnt_width(FILTER_SIZE);
  localparam int IN_PLANE  = INPUT_SIZE * INPUT_SIZE;
  localparam int OUT_PLANE = OUT_SIZE * OUT_SIZE;

  localparam logic [FW-1:0]  F_MAX  = FW'(NUM_FILTERS - 1);
  localparam logic [OW-1:0]  O_MAX  = OW'(OUT_SIZE - 1);
  localparam logic [CHW-1:0] C_MAX  = CHW'(NUM_CHANNELS - 1);
  localparam logic [KW-1:0]  K_MAX  = KW'(FILTER_SIZE - 1);
  localparam logic [FW-1:0]  F_ZERO = {FW{1'b0}};
  localparam logic [OW-1:0]  O_ZERO = {OW{1'b0}};
  localparam logic [CHW-1:0] C_ZERO = {CHW{1'b0}};
  localparam logic [KW-1:0]  K_ZERO = {KW{1'b0}};

  state_t             r_state, w_state_nxt;
  logic [FW-1:0]      r_f, w_f_nxt;
  logic [OW-1:0]      r_oy, r_ox, w_oy_nxt, w_ox_nxt;
  logic [CHW-1:0]     r_c, w_c_nxt;
  logic [KW-1:0]      r_ky, r_kx, w_ky_nxt, w_kx_nxt;
  logic               r_tap_vld;
  logic [IN_AW-1:0]   r_in_addr, w_in_addr_nxt;
  logic [W_AW-1:0]    r_w_addr, w_w_addr_nxt;
  logic [OUT_AW-1:0]  r_out_addr, w_out_addr_cur;
  logic               r_busy, r_done, r_out_valid;
  logic               w_last_tap, w_last_px, w_tap_first;
  logic [31:0]        w_result;

  assign w_last_tap  = (r_c == C_MAX) && (r_ky == K_MAX) && (r_kx == K_MAX);
  assign w_last_px   = (r_f == F_MAX) && (r_oy == O_MAX) && (r_ox == O_MAX);
  assign w_tap_first = (r_state == S_FETCH) && (r_c == C_ZERO) && (r_ky == K_ZERO) && (r_kx == K_ZERO);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_FETCH; else w_state_nxt = S_IDLE;
      S_FETCH: if (w_last_tap) w_state_nxt = S_DRAIN; else w_state_nxt = S_FETCH;
      S_DRAIN: w_state_nxt = S_WRITE;
      S_WRITE: begin
        if (out_ready) begin
          if (w_last_px) w_state_nxt = S_FIN; else w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      S_FIN:   if (start) w_state_nxt = S_FETCH; else w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tap and pixel counter next values (kx innermost, then ky, then channel)
  always_comb begin
    w_f_nxt  = r_f;
    w_oy_nxt = r_oy;
    w_ox_nxt = r_ox;
    w_c_nxt  = r_c;
    w_ky_nxt = r_ky;
    w_kx_nxt = r_kx;
    case (r_state)
      S_IDLE, S_FIN: begin
        if (start) begin
          w_f_nxt  = F_ZERO;
          w_oy_nxt = O_ZERO;
          w_ox_nxt = O_ZERO;
          w_c_nxt  = C_ZERO;
          w_ky_nxt = K_ZERO;
          w_kx_nxt = K_ZERO;
        end else begin
          w_f_nxt  = r_f;
        end
      end
      S_FETCH: begin
        if (r_kx == K_MAX) begin
          w_kx_nxt = K_ZERO;
          if (r_ky == K_MAX) begin
            w_ky_nxt = K_ZERO;
            if (r_c == C_MAX) w_c_nxt = C_ZERO; else w_c_nxt = r_c + 1'b1;
          end else begin
            w_ky_nxt = r_ky + 1'b1;
          end
        end else begin
          w_kx_nxt = r_kx + 1'b1;
        end
      end
      S_WRITE: begin
        if (out_ready && !w_last_px) begin
          if (r_ox == O_MAX) begin
            w_ox_nxt = O_ZERO;
            if (r_oy == O_MAX) begin
              w_oy_nxt = O_ZERO;
              w_f_nxt  = r_f + 1'b1;
            end else begin
              w_oy_nxt = r_oy + 1'b1;
            end
          end else begin
            w_ox_nxt = r_ox + 1'b1;
          end
        end else begin
          w_ox_nxt = r_ox;
        end
      end
      default: w_f_nxt = r_f;
    endcase
  end

  assign w_in_addr_nxt = IN_AW'(int'(w_c_nxt) * IN_PLANE
                              + (int'(w_oy_nxt) * STRIDE + int'(w_ky_nxt)) * INPUT_SIZE
                              + int'(w_ox_nxt) * STRIDE + int'(w_kx_nxt));
  assign w_w_addr_nxt  = W_AW'(((int'(w_f_nxt) * NUM_CHANNELS + int'(w_c_nxt)) * FILTER_SIZE
                              + int'(w_ky_nxt)) * FILTER_SIZE + int'(w_kx_nxt));
  assign w_out_addr_cur = OUT_AW'(int'(r_f) * OUT_PLANE + int'(r_oy) * OUT_SIZE + int'(r_ox));

  // Counters, addresses and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f         <= F_ZERO;
      r_oy        <= O_ZERO;
      r_ox        <= O_ZERO;
      r_c         <= C_ZERO;
      r_ky        <= K_ZERO;
      r_kx        <= K_ZERO;
      r_tap_vld   <= 1'b0;
      r_in_addr   <= {IN_AW{1'b0}};
      r_w_addr    <= {W_AW{1'b0}};
      r_out_addr  <= {OUT_AW{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_f       <= w_f_nxt;
      r_oy      <= w_oy_nxt;
      r_ox      <= w_ox_nxt;
      r_c       <= w_c_nxt;
      r_ky      <= w_ky_nxt;
      r_kx      <= w_kx_nxt;
      r_tap_vld <= (r_state == S_FETCH);
      // Addresses only move when a tap is issued, so they hold through DRAIN/WRITE.
      if (w_state_nxt == S_FETCH) begin
        r_in_addr <= w_in_addr_nxt;
        r_w_addr  <= w_w_addr_nxt;
      end else begin
        r_in_addr <= r_in_addr;
        r_w_addr  <= r_w_addr;
      end
      if (r_state == S_DRAIN) begin
        r_out_addr <= w_out_addr_cur;
      end else begin
        r_out_addr <= r_out_addr;
      end
      r_busy      <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_DRAIN) || (w_state_nxt == S_WRITE);
      r_done      <= (w_state_nxt == S_FIN);
      r_out_valid <= (w_state_nxt == S_WRITE);
    end
  end

  conv_mac #(
    .FRAC_BITS (FRAC_BITS),
    .RELU_EN   (RELU_EN)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .i_preset   (w_tap_first),
    .i_bias     (bias[int'(r_f)*32 +: 32]),
    .i_acc_en   (r_tap_vld),
    .i_data     (input_data),
    .i_weight   (filter_weights),
    .i_load_out (r_state == S_DRAIN),
    .o_result   (w_result)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign in_addr     = r_in_addr;
  assign w_addr      = r_w_addr;
  assign out_valid   = r_out_valid;
  assign out_addr    = r_out_addr;
  assign output_data = w_result;

endmodule

// File: tb/tb_conv_layer_seq.sv
// Self-checking bench for conv_layer_seq: directed and random passes compared
// against a plain-arithmetic convolution model.
module tb_conv_layer_seq;

  localparam int NF   = 2;
  localparam int NC   = 2;
  localparam int IS   = 4;
  localparam int FS   = 2;
  localparam int ST   = 2;
  localparam int FB   = 0;
  localparam int RELU = 1;
  localparam int OS   = (IS - FS) / ST + 1;
  localparam int NPX  = NF * OS * OS;
  localparam int TAPS = NC * FS * FS;
  localparam int PASS_CYC = NPX * (TAPS + 2) + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic        busy, done, out_valid;
  logic [4:0]  in_addr;
  logic [3:0]  w_addr;
  logic [2:0]  out_addr;
  logic [31:0] input_data, filter_weights, output_data;
  logic [63:0] bias;

  logic [31:0] in_mem [NC*IS*IS];
  logic [31:0] w_mem  [NF*NC*FS*FS];
  logic [31:0] bias_v [NF];
  logic [31:0] got    [NPX];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;
  int          exp_a[$];
  logic [31:0] exp_d[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc            <= cyc + 1;
    input_data     <= in_mem[in_addr];
    filter_weights <= w_mem[w_addr];
  end

  assign bias = {bias_v[1], bias_v[0]};

  conv_layer_seq #(
    .NUM_FILTERS(NF), .NUM_CHANNELS(NC), .INPUT_SIZE(IS), .FILTER_SIZE(FS),
    .STRIDE(ST), .FRAC_BITS(FB), .RELU_EN(RELU)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .input_data(input_data), .w_addr(w_addr),
    .filter_weights(filter_weights), .bias(bias), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .output_data(output_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pix(input int c, input int y, input int x);
    return in_mem[(c * IS + y) * IS + x];
  endfunction

  // Reference: plain convolution sum, then shift, clamp and optional ReLU.
  function automatic logic [31:0] model_px(input int f, input int oy, input int ox);
    longint acc;
    acc = longint'($signed(bias_v[f])) * (longint'(1) << FB);
    for (int c = 0; c < NC; c++)
      for (int ky = 0; ky < FS; ky++)
        for (int kx = 0; kx < FS; kx++)
          acc += longint'($signed(pix(c, oy*ST + ky, ox*ST + kx)))
               * longint'($signed(w_mem[((f*NC + c)*FS + ky)*FS + kx]));
    acc = acc >>> FB;
    if (acc > 64'sd2147483647) acc = 64'sd2147483647;
    if (acc < -64'sd2147483648) acc = -64'sd2147483648;
    if (RELU != 0 && acc < 0) acc = 0;
    return acc[31:0];
  endfunction

  task automatic load_expect();
    exp_a.delete();
    exp_d.delete();
    for (int f = 0; f < NF; f++)
      for (int oy = 0; oy < OS; oy++)
        for (int ox = 0; ox < OS; ox++) begin
          exp_a.push_back(f*OS*OS + oy*OS + ox);
          exp_d.push_back(model_px(f, oy, ox));
        end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NC*IS*IS; i++) in_mem[i] = 32'($signed($urandom_range(0, 65535)) - 32768);
    for (int i = 0; i < NF*NC*FS*FS; i++) w_mem[i] = 32'($signed($urandom_range(0, 65535)) - 32768);
    for (int i = 0; i < NF; i++) bias_v[i] = 32'($signed($urandom_range(0, 1048575)) - 524288);
  endtask

  task automatic run_pass(input string tag, input bit b2b, input int extra_start,
                          input bit stall, input int abort_after, input bit keep_going);
    int k;
    int wait_cnt = 0;
    int hold = 0;
    bit fin_seen = 1'b0;
    bit stall_seen = 1'b0;
    bit aborted = 1'b0;
    logic [31:0] h_d;
    logic [2:0]  h_oa;
    logic [4:0]  h_ia;
    logic [3:0]  h_wa;
    load_expect();
    n_acc = 0;
    if (!b2b) begin
      @(posedge clk); #1;
    end
    if (stall) out_ready = 1'b0;
    start = 1'b1;
    k = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = (extra_start >= 0 && i == extra_start);
      if (stall && out_valid && !stall_seen) begin
        stall_seen = 1'b1;
        h_d = output_data; h_oa = out_addr; h_ia = in_addr; h_wa = w_addr;
      end else if (stall_seen && hold < 10) begin
        check({tag, "_stall_valid"}, out_valid, 1);
        check({tag, "_stall_oaddr"}, out_addr, h_oa);
        check({tag, "_stall_data"}, output_data, h_d);
        check({tag, "_stall_iaddr"}, {in_addr, w_addr}, {h_ia, h_wa});
        hold++;
        if (hold == 10) out_ready = 1'b1;
      end
      if (abort_after >= 0 && n_acc == abort_after && !out_valid) begin
        wait_cnt++;
        if (wait_cnt == 3) begin
          rst = 1'b1;
          @(posedge clk); #1;
          check({tag, "_rst_status"}, {busy, done, out_valid}, 3'b000);
          check({tag, "_rst_addrs"}, {in_addr, w_addr, out_addr}, 12'd0);
          check({tag, "_rst_data"}, output_data, 32'd0);
          start = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          start = 1'b0;
          for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            if (done || busy) fin_seen = 1'b1;
          end
          check({tag, "_abort_quiet"}, fin_seen, 0);
          aborted = 1'b1;
          break;
        end
      end
      if (done) begin
        fin_seen = 1'b1;
        break;
      end
    end
    if (abort_after >= 0) begin
      check({tag, "_aborted"}, aborted, 1);
      exp_a.delete();
      exp_d.delete();
    end else begin
      check({tag, "_done_seen"}, fin_seen, 1);
      check({tag, "_outputs"}, n_acc, NPX);
      check({tag, "_busy_at_done"}, busy, 0);
      if (!stall) check({tag, "_cycles"}, cyc - k + 1, PASS_CYC);
      if (!keep_going) begin
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {done, busy}, 2'b00);
      end
    end
  endtask

  initial begin
    fork
      begin : compare
        int a;
        logic [31:0] d;
        forever begin
          @(negedge clk);
          if (!rst && out_valid && out_ready) begin
            if (exp_a.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL out_unexpected: addr %0d accepted, required no output", out_addr);
            end else begin
              a = exp_a.pop_front();
              d = exp_d.pop_front();
              check("out_addr", out_addr, a);
              check("out_data", output_data, d);
              got[out_addr] = output_data;
              n_acc++;
            end
          end
        end
      end
    join_none

    for (int i = 0; i < NC*IS*IS; i++) in_mem[i] = 32'd0;
    for (int i = 0; i < NF*NC*FS*FS; i++) w_mem[i] = 32'd0;
    for (int i = 0; i < NF; i++) bias_v[i] = 32'd0;
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_status", {busy, done, out_valid}, 3'b000);
    check("reset_addrs", {in_addr, w_addr, out_addr}, 12'd0);
    check("reset_data", output_data, 32'd0);
    start = 1'b0;
    rst = 1'b0;

    // Single channel (channel 1 zero), weights 1, bias 0.
    for (int i = 0; i < IS*IS; i++) in_mem[i] = 32'(i + 1);
    for (int i = 0; i < NF*NC*FS*FS; i++) w_mem[i] = 32'd1;
    check("model_pin_14", model_px(0, 0, 0), 32'd14);
    run_pass("single", 1'b0, -1, 1'b0, -1, 1'b0);
    check("lit_px0", got[0], 32'd14);
    check("lit_px1", got[1], 32'd22);
    check("lit_px2", got[2], 32'd46);
    check("lit_px3", got[3], 32'd54);

    // Two identical channels, bias 5, with a stalled first write.
    for (int i = 0; i < IS*IS; i++) in_mem[IS*IS + i] = 32'(i + 1);
    bias_v[0] = 32'd5;
    bias_v[1] = 32'd5;
    run_pass("dual", 1'b0, -1, 1'b1, -1, 1'b0);
    check("lit_dual0", got[0], 32'd33);
    check("lit_dual3", got[3], 32'd113);
    check("lit_dual7", got[7], 32'd113);

    // Saturation high (filter 0) and low-then-ReLU (filter 1); stray start mid-pass.
    for (int i = 0; i < NC*IS*IS; i++) in_mem[i] = 32'h4000_0000;
    for (int i = 0; i < NC*FS*FS; i++) begin
      w_mem[i] = 32'd1;
      w_mem[NC*FS*FS + i] = 32'hFFFF_FFFF;
    end
    bias_v[0] = 32'd0;
    bias_v[1] = 32'd0;
    run_pass("sat", 1'b0, 20, 1'b0, -1, 1'b0);
    check("lit_sat_hi", got[0], 32'h7FFF_FFFF);
    check("lit_sat_lo", got[5], 32'd0);

    // Abort during pixel 2, then full passes, the last two back to back.
    fill_random();
    run_pass("abort", 1'b0, -1, 1'b0, 2, 1'b0);
    run_pass("rerun", 1'b0, -1, 1'b0, -1, 1'b1);
    fill_random();
    run_pass("b2b", 1'b1, -1, 1'b0, -1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_pass("rand", 1'b0, -1, 1'b0, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
